// File: rtl/bcd_chain_counter_if.sv
// bcd_chain_counter_if
// Bundles the control, load and status signals of one bcd_chain_counter.
//   en, up, load, din : driven by the controller (master) into the counter
//   count, tc, wrap,
//   load_err          : driven by the counter (slave) back to the controller
// Cascading is done outside the interface: tc of one instance drives en of
// the next instance's interface.
interface bcd_chain_counter_if #(
   parameter int W      = 4,
   parameter int DIGITS = 2
);
   logic                  en;
   logic                  up;
   logic                  load;
   logic [DIGITS*W-1:0]   din;
   logic [DIGITS*W-1:0]   count;
   logic                  tc;
   logic                  wrap;
   logic                  load_err;

   modport master (
      output en, up, load, din,
      input  count, tc, wrap, load_err
   );

   modport slave (
      input  en, up, load, din,
      output count, tc, wrap, load_err
   );
endinterface

// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter
// Cascade of DIGITS stages, each counting modulo MOD in W bits, with
// synchronous parallel load (per-digit range check), count enable, direction
// control, combinational terminal count and registered wrap / load_err pulses.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (count=0, wrap=0, load_err=0)
//   bus  : bcd_chain_counter_if.slave (en, up, load, din -> count, tc,
//          wrap, load_err); digit k sits at bits [k*W+W-1 : k*W]
module bcd_chain_counter #(
   parameter int MOD    = 10,
   parameter int W      = 4,
   parameter int DIGITS = 2
) (
   input  logic               clk,
   input  logic               rst,
   bcd_chain_counter_if.slave bus
);

   // W+1 bits so MOD = 2^W is representable for the range compare.
   localparam logic [W:0]   MOD_EXT = (W+1)'(MOD);
   localparam logic [W-1:0] MAX_D   = W'(MOD-1);
   localparam logic [W-1:0] ONE_D   = W'(1);

   logic [DIGITS*W-1:0] count_q;
   logic [DIGITS*W-1:0] count_nxt;
   logic                wrap_q;
   logic                wrap_nxt;
   logic                err_q;
   logic                err_nxt;
   logic                all_max;
   logic                all_zero;
   logic                step;

   function automatic logic legal(input logic [W-1:0] d);
      return {1'b0, d} < MOD_EXT;
   endfunction

   always_comb begin
      all_max  = 1'b1;
      all_zero = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         all_max  = all_max  & (count_q[k*W +: W] == MAX_D);
         all_zero = all_zero & (count_q[k*W +: W] == '0);
      end
   end

   assign bus.tc = bus.en & (bus.up ? all_max : all_zero);

   always_comb begin
      count_nxt = count_q;
      wrap_nxt  = 1'b0;
      err_nxt   = 1'b0;
      step      = 1'b1;
      if (bus.load) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (legal(bus.din[k*W +: W])) begin
               count_nxt[k*W +: W] = bus.din[k*W +: W];
            end else begin
               count_nxt[k*W +: W] = '0;
               err_nxt             = 1'b1;
            end
         end
      end else if (bus.en) begin
         wrap_nxt = bus.up ? all_max : all_zero;
         // step means "every lower digit sits at its boundary". An illegal
         // digit equals neither MAX_D nor 0, so it also blocks the carry.
         for (int k = 0; k < DIGITS; k++) begin
            if (!legal(count_q[k*W +: W])) begin
               count_nxt[k*W +: W] = '0;
            end else if (step) begin
               if (bus.up) begin
                  count_nxt[k*W +: W] = (count_q[k*W +: W] == MAX_D) ?
                                        '0 : count_q[k*W +: W] + ONE_D;
               end else begin
                  count_nxt[k*W +: W] = (count_q[k*W +: W] == '0) ?
                                        MAX_D : count_q[k*W +: W] - ONE_D;
               end
            end
            step = step & (bus.up ? (count_q[k*W +: W] == MAX_D)
                                  : (count_q[k*W +: W] == '0));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         wrap_q  <= wrap_nxt;
         err_q   <= err_nxt;
      end
   end

   assign bus.count    = count_q;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
module tb_bcd_chain_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // a: MOD 10, 2 digits; b: MOD 7, W 3, 3 digits; c0/c1: cascaded single digits
   bcd_chain_counter_if #(.W(4), .DIGITS(2)) if_a ();
   bcd_chain_counter_if #(.W(3), .DIGITS(3)) if_b ();
   bcd_chain_counter_if #(.W(4), .DIGITS(1)) if_c0 ();
   bcd_chain_counter_if #(.W(4), .DIGITS(1)) if_c1 ();

   bcd_chain_counter #(.MOD(10), .W(4), .DIGITS(2)) u_a  (.clk(clk), .rst(rst), .bus(if_a));
   bcd_chain_counter #(.MOD(7),  .W(3), .DIGITS(3)) u_b  (.clk(clk), .rst(rst), .bus(if_b));
   bcd_chain_counter #(.MOD(10), .W(4), .DIGITS(1)) u_c0 (.clk(clk), .rst(rst), .bus(if_c0));
   bcd_chain_counter #(.MOD(10), .W(4), .DIGITS(1)) u_c1 (.clk(clk), .rst(rst), .bus(if_c1));

   assign if_c1.en = if_c0.tc;
   assign if_c1.up = if_c0.up;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: the count is held as one integer in base MOD.
   function automatic int top_of(input int mod, input int nd);
      int t = 1;
      for (int k = 0; k < nd; k++) t = t * mod;
      return t;
   endfunction

   function automatic int pack(input int mod, input int w, input int nd, input int val);
      int r = 0;
      int v = val;
      for (int k = 0; k < nd; k++) begin
         r = r | ((v % mod) << (k*w));
         v = v / mod;
      end
      return r;
   endfunction

   task automatic mstep(input int mod, input int w, input int nd, input int val,
                        input bit ld, input bit en, input bit up, input int din,
                        output int nval, output bit nwr, output bit nerr);
      int top = top_of(mod, nd);
      int pw  = 1;
      int dg;
      nval = val;
      nwr  = 1'b0;
      nerr = 1'b0;
      if (ld) begin
         nval = 0;
         for (int k = 0; k < nd; k++) begin
            dg = (din >> (k*w)) & ((1 << w) - 1);
            if (dg >= mod) begin
               nerr = 1'b1;
               dg   = 0;
            end
            nval = nval + dg*pw;
            pw   = pw * mod;
         end
      end else if (en) begin
         if (up) begin
            nwr  = (val == top-1);
            nval = (val + 1) % top;
         end else begin
            nwr  = (val == 0);
            nval = (val + top - 1) % top;
         end
      end
   endtask

   task automatic cyc_a(input bit ld, input bit en, input bit up, input logic [7:0] din);
      @(negedge clk);
      if_a.load = ld;
      if_a.en   = en;
      if_a.up   = up;
      if_a.din  = din;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] cnt, input bit wr, input bit er);
      chk({tag, "_count"}, if_a.count, cnt);
      chk({tag, "_wrap"},  if_a.wrap,  wr);
      chk({tag, "_err"},   if_a.load_err, er);
   endtask

   int a_val, b_val, nv;
   bit nw, ne;
   bit a_ld, a_en, a_up, b_ld, b_en, b_up;
   logic [31:0] a_din, b_din;

   initial begin
      if_a.load = 0; if_a.en = 0; if_a.up = 1; if_a.din = '0;
      if_b.load = 0; if_b.en = 0; if_b.up = 1; if_b.din = '0;
      if_c0.load = 0; if_c0.en = 0; if_c0.up = 1; if_c0.din = '0;
      if_c1.load = 0; if_c1.din = '0;

      #12;
      chk_a("reset", 8'h00, 0, 0);
      chk("reset_b", if_b.count, 0);
      @(negedge clk) rst = 1'b0;

      // async reset mid-count
      cyc_a(1, 0, 1, 8'h37);
      chk_a("ld37", 8'h37, 0, 0);
      cyc_a(0, 1, 1, 8'h00);
      chk_a("up38", 8'h38, 0, 0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk_a("async_rst", 8'h00, 0, 0);
      if_a.en = 0;
      @(negedge clk) rst = 1'b0;
      cyc_a(0, 1, 1, 8'h00);
      chk_a("post_rst", 8'h01, 0, 0);

      // up wrap
      cyc_a(1, 0, 1, 8'h98);
      chk_a("ld98", 8'h98, 0, 0);
      cyc_a(0, 1, 1, 8'h00);
      chk_a("up99", 8'h99, 0, 0);
      chk("tc_99", if_a.tc, 1);
      cyc_a(0, 1, 1, 8'h00);
      chk_a("up_wrap", 8'h00, 1, 0);
      chk("tc_00_up", if_a.tc, 0);
      cyc_a(0, 0, 1, 8'h00);
      chk_a("wrap_clr", 8'h00, 0, 0);

      // down borrow
      cyc_a(1, 0, 0, 8'h10);
      cyc_a(0, 1, 0, 8'h00);
      chk_a("dn09", 8'h09, 0, 0);
      cyc_a(0, 1, 0, 8'h00);
      chk_a("dn08", 8'h08, 0, 0);
      cyc_a(1, 1, 0, 8'h00);
      chk_a("ld00", 8'h00, 0, 0);
      chk("tc_00_dn", if_a.tc, 1);
      cyc_a(0, 1, 0, 8'h00);
      chk_a("dn_wrap", 8'h99, 1, 0);

      // invalid load
      cyc_a(1, 0, 1, 8'h3A);
      chk_a("ld3A", 8'h30, 0, 1);
      cyc_a(0, 0, 1, 8'h00);
      chk_a("err_clr", 8'h30, 0, 0);
      cyc_a(1, 0, 1, 8'hFF);
      chk_a("ldFF", 8'h00, 0, 1);
      cyc_a(1, 0, 1, 8'h45);
      chk_a("ld45", 8'h45, 0, 0);

      // priority and hold
      cyc_a(1, 1, 1, 8'h21);
      chk_a("ld_pri", 8'h21, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc_a(0, 0, 1, 8'h99);
         chk_a("hold", 8'h21, 0, 0);
         chk("hold_tc", if_a.tc, 0);
      end

      // cascade
      @(negedge clk);
      if_c0.load = 1; if_c0.din = 4'h9;
      if_c1.load = 1; if_c1.din = 4'h0;
      @(posedge clk); #1;
      @(negedge clk);
      if_c0.load = 0; if_c1.load = 0;
      if_c0.en = 1; if_c0.up = 1;
      #1;
      chk("casc_tc", if_c0.tc, 1);
      @(posedge clk); #1;
      chk("casc_val", {if_c1.count, if_c0.count}, 8'h10);
      chk("casc_wrap0", if_c0.wrap, 1);
      chk("casc_wrap1", if_c1.wrap, 0);
      @(negedge clk) if_c0.en = 0;

      // randomized run against the base-MOD integer model
      @(negedge clk) rst = 1'b1;
      if_a.load = 0; if_a.en = 0;
      #2 rst = 1'b0;
      a_val = 0;
      b_val = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         a_ld = ($urandom_range(7) == 0);
         a_en = ($urandom_range(3) != 0);
         a_up = ($urandom_range(3) != 0);
         a_din = $urandom & 32'hFF;
         b_ld = ($urandom_range(9) == 0);
         b_en = ($urandom_range(3) != 0);
         b_up = (i % 200) < 120;
         b_din = $urandom & 32'h1FF;
         if_a.load = a_ld; if_a.en = a_en; if_a.up = a_up; if_a.din = a_din[7:0];
         if_b.load = b_ld; if_b.en = b_en; if_b.up = b_up; if_b.din = b_din[8:0];
         #1;
         chk("rnd_a_tc", if_a.tc, a_en && (a_up ? a_val == 99 : a_val == 0));
         chk("rnd_b_tc", if_b.tc, b_en && (b_up ? b_val == 342 : b_val == 0));
         @(posedge clk);
         #1;
         mstep(10, 4, 2, a_val, a_ld, a_en, a_up, int'(a_din), nv, nw, ne);
         a_val = nv;
         chk("rnd_a_count", if_a.count, pack(10, 4, 2, a_val));
         chk("rnd_a_wrap",  if_a.wrap, nw);
         chk("rnd_a_err",   if_a.load_err, ne);
         mstep(7, 3, 3, b_val, b_ld, b_en, b_up, int'(b_din), nv, nw, ne);
         b_val = nv;
         chk("rnd_b_count", if_b.count, pack(7, 3, 3, b_val));
         chk("rnd_b_wrap",  if_b.wrap, nw);
         chk("rnd_b_err",   if_b.load_err, ne);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
